// File: rtl/riscv_crypto_aes_pkg.sv
// Shared types and constants for the AES column sequencer and its neighbours.
package riscv_crypto_aes_pkg;

  localparam int unsigned AES_COL_STEPS = 4;
  localparam int unsigned STEP_W        = 2;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned OP_W          = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} aes_col_state_e;

  // ShiftRows walks the state forward; InvShiftRows walks it backward.
  function automatic logic [STEP_W-1:0] col_index(input logic [STEP_W-1:0] j,
                                                  input logic [STEP_W-1:0] step,
                                                  input logic              dec);
    return dec ? STEP_W'(j - step) : STEP_W'(j + step);
  endfunction

  // Opcode strobes packed as {encs, encsm, decs, decsm}.
  function automatic logic [OP_W-1:0] op_sel(input logic dec, input logic mix);
    return {~dec & ~mix, ~dec & mix, dec & ~mix, dec & mix};
  endfunction

endpackage

// File: rtl/riscv_crypto_aes_col_seq.sv
// Issues four byte-wise saes32 operations to build one AES round output column.
module riscv_crypto_aes_col_seq
  import riscv_crypto_aes_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_dec,
  input  logic        in_mix,
  input  logic [1:0]  in_col_idx,
  input  logic [31:0] in_s0,
  input  logic [31:0] in_s1,
  input  logic [31:0] in_s2,
  input  logic [31:0] in_s3,
  input  logic [31:0] in_rkey,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_col,
  output logic [31:0] fu_rs1,
  output logic [31:0] fu_rs2,
  output logic [1:0]  fu_bs,
  output logic        fu_op_encs,
  output logic        fu_op_encsm,
  output logic        fu_op_decs,
  output logic        fu_op_decsm,
  input  logic [31:0] fu_rd
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(AES_COL_STEPS - 1);

  aes_col_state_e             state;
  logic [WORD_W-1:0]          acc;
  logic [STEP_W-1:0]          step;
  logic [STEP_W-1:0]          step_nxt;
  logic [3:0][WORD_W-1:0]     st;
  logic [3:0][WORD_W-1:0]     in_st;
  logic                       dec;
  logic                       col_j_unused_guard;
  logic [STEP_W-1:0]          col_j;
  logic [OP_W-1:0]            ops;

  assign in_st    = {in_s3, in_s2, in_s1, in_s0};
  assign step_nxt = step + STEP_W'(1);
  assign col_j_unused_guard = 1'b0;

  assign {fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm} = ops;

  // Single-process FSM; every output is a register updated here.
  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state     <= IDLE;
      acc       <= '0;
      step      <= '0;
      st        <= '0;
      dec       <= 1'b0;
      col_j     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_col   <= '0;
      fu_rs1    <= '0;
      fu_rs2    <= '0;
      fu_bs     <= '0;
      ops       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= RUN;
            st       <= in_st;
            dec      <= in_dec;
            col_j    <= in_col_idx;
            acc      <= in_rkey;
            step     <= '0;
            in_ready <= 1'b0;
            // Step 0 selects column j in both directions.
            fu_rs1   <= in_rkey;
            fu_rs2   <= in_st[in_col_idx];
            fu_bs    <= '0;
            ops      <= op_sel(in_dec, in_mix);
          end
        end

        RUN: begin
          acc  <= fu_rd;
          step <= step_nxt;
          if (step == LAST_STEP) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_col   <= fu_rd;
            fu_rs1    <= '0;
            fu_rs2    <= '0;
            fu_bs     <= '0;
            ops       <= '0;
          end else begin
            fu_rs1 <= fu_rd;
            fu_rs2 <= st[col_index(col_j, step_nxt, dec)];
            fu_bs  <= step_nxt;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
